ex_hazard_ctrl: RTL and testbench
=================================

# ex_hazard_ctrl

Hazard and forwarding controller for the execute stage of the 64-bit pipelined ARM core. It shadows the destination-register metadata of the instructions in EX, MEM and WB. It also:
- registers the operand-forwarding selects that steer `data_a_ex` / `data_b_ex` during EX;
- raises a one-cycle load-use stall;
- selects live ALU flags versus the flag registers for a conditional branch that immediately follows a flag-setting instruction.

It sits between ID/EX pipeline control and the EX datapath.

## Interface
- `XZR`, default 31: register index that never creates a hazard or a forward.
- `CNT_W`, default 32: width of the stall-event counter.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the instruction in ID is real, not a bubble.
- `id_rn` in 5: source A register of the ID instruction.
- `id_rm` in 5: source B register of the ID instruction (Rd for STUR/CBZ, supplied by decode).
- `id_uses_rn` in 1: the ID instruction reads `id_rn`.
- `id_uses_rm` in 1: the ID instruction reads `id_rm`.
- `id_rd` in 5: destination register of the ID instruction.
- `id_regwrite` in 1: the ID instruction writes `id_rd`.
- `id_memread` in 1: the ID instruction is a load.
- `id_setflags` in 1: the ID instruction sets flags (`flag_en`).
- `id_reads_flags` in 1: the ID instruction is B.cond.
- `flush` in 1: a taken branch squashes the ID instruction this cycle.
- `stall` out 1: hold PC and IF/ID; insert a bubble into EX (combinational).
- `fwd_a` out 2: EX operand-A select (registered). 00 = register file, 01 = MEM-stage ALU result, 10 = WB-stage write data.
- `fwd_b` out 2: EX operand-B select, same encoding as `fwd_a`.
- `flag_sel` out 1: 1 = B.cond in ID uses live ALU flags from EX; 0 = uses the flag registers (combinational).
- `stall_count` out `CNT_W`: saturating count of stall cycles.

## Operation
- **Shadow slots.** Three slots: EX {valid, rd, regwrite, memread, setflags}, MEM {valid, rd, regwrite}, WB {valid, rd, regwrite}.
- **Slot advance.** Every cycle WB←MEM and MEM←EX. EX←ID fields gated by `id_valid & ~stall & ~flush`; otherwise EX gets a bubble (valid=0).
- **Match(r, slot)** = slot.valid & slot.regwrite & slot.rd==r & r!=`XZR`.
- **Load-use stall.** `stall` = `id_valid & ~flush & EX.memread & ((id_uses_rn & Match(id_rn,EX)) | (id_uses_rm & Match(id_rm,EX)))`.
- **Forward select, next `fwd_a`, computed at the end of the ID cycle:**
  - if `~id_valid | ~id_uses_rn | stall | flush` → 00;
  - else if Match(id_rn, EX) → 01 (producer will be in MEM);
  - else if Match(id_rn, MEM) → 10 (producer will be in WB);
  - else → 00.
- **`fwd_b`** follows the same rule using `id_rm` / `id_uses_rm`.
- **Priority.** The nearer producer (EX slot) always wins over MEM.
- **WB-slot producers need no forward.** The register file writes first half and reads second half. The WB slot exists only for bookkeeping and debug.
- **`flag_sel`** = `id_valid & id_reads_flags & EX.valid & EX.setflags`.
- **`stall_count`** increments on every cycle with `stall`=1 and saturates at all-ones.

## Timing
- Reset (async, `reset`=0):
  - all slots invalid;
  - `fwd_a`=`fwd_b`=00;
  - `stall_count`=0.
  - `stall`=0 and `flag_sel`=0 follow, because all slots are invalid.
  - Outputs are valid the first edge after `reset` deasserts.
- `stall` and `flag_sel` are combinational from the ID inputs and the current slots, in the same cycle.
- `fwd_a` and `fwd_b` are registered. The value computed in the ID cycle is presented during the following EX cycle, aligned with `data_a_ex` / `data_b_ex`.
- **Load-use latency.** The consumer stalls exactly 1 cycle. On the re-evaluation the load is in the MEM slot, so the select is 10.
- **`flush` together with a hazard:** `flush` wins. `stall`=0, EX gets a bubble, forwards are 00, and the counter does not increment.
- **Back-to-back producers of the same register:** the newest one (EX slot) forwards.
- **Reset mid-stall:** the stall drops immediately and slot contents are discarded.

## Test plan
- **ALU→ALU forward.** ADD X1 in ID, then SUB X2,X1,X3 next cycle. Required: `stall`=0; in SUB's EX cycle `fwd_a`=01, `fwd_b`=00.
- **Distance-2 forward and priority.**
  - ADD X1, NOP, then ORR X4,X5,X1. Required: `fwd_b`=10.
  - ADD X1, ADD X1, then ORR X4,X5,X1. Required: `fwd_b`=01.
- **Load-use.** LDUR X7 then ADD X8,X7,X7. Required:
  - `stall`=1 for exactly one cycle and `stall_count` goes 0→1;
  - EX receives a bubble;
  - ADD enters EX with `fwd_a`=`fwd_b`=10.
- **XZR and non-readers.**
  - LDUR X31 followed by ADD X2,X31,X31. Required: `stall`=0, forwards 00.
  - `id_uses_rm`=0 with a matching `id_rm`. Required: `fwd_b`=00.
- **Flag forward.** SUBS in EX with B.cond in ID. Required: `flag_sel`=1. With one instruction in between: `flag_sel`=0.
- **Flush and reset priority.**
  - A load-use hazard with `flush`=1. Required: `stall`=0, counter unchanged.
  - `reset` low during a stall. Required: `stall`=0, `fwd_a`=`fwd_b`=00, `stall_count`=0 asynchronously.

Source files
------------

// File: rtl/ex_hazard_ctrl_if.sv
// rtl/ex_hazard_ctrl_if.sv - ID-stage hazard request and EX control response bundle
interface ex_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic [4:0]       id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_setflags;
  logic             id_reads_flags;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             flag_sel;
  logic [CNT_W-1:0] stall_count;
  logic             dbg_wb_write;
  logic [4:0]       dbg_wb_rd;

  modport master (
    output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd,
           id_regwrite, id_memread, id_setflags, id_reads_flags, flush,
    input  stall, fwd_a, fwd_b, flag_sel, stall_count, dbg_wb_write, dbg_wb_rd
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd,
           id_regwrite, id_memread, id_setflags, id_reads_flags, flush,
    output stall, fwd_a, fwd_b, flag_sel, stall_count, dbg_wb_write, dbg_wb_rd
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage load-use stall, operand forward and flag-source control
module ex_hazard_ctrl #(
  parameter int XZR   = 31,
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             reset,
  ex_hazard_ctrl_if.slave bus
);

  localparam logic [4:0] XZR_IDX = 5'(XZR);

  logic             r_ex_valid;
  logic [4:0]       r_ex_rd;
  logic             r_ex_regwrite;
  logic             r_ex_memread;
  logic             r_ex_setflags;
  logic             r_mem_valid;
  logic [4:0]       r_mem_rd;
  logic             r_mem_regwrite;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic             r_wb_regwrite;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_ex_hit_a;
  logic       w_ex_hit_b;
  logic       w_mem_hit_a;
  logic       w_mem_hit_b;
  logic       w_stall;
  logic       w_flag_sel;
  logic       w_ex_load;
  logic [1:0] w_fwd_a_nxt;
  logic [1:0] w_fwd_b_nxt;

  function automatic logic f_match(input logic [4:0] r, input logic v,
                                   input logic rw, input logic [4:0] rd);
    return v && rw && (rd == r) && (r != XZR_IDX);
  endfunction

  // EX-slot hit is checked first so the newest producer wins
  function automatic logic [1:0] f_fwd(input logic kill, input logic uses,
                                       input logic ex_hit, input logic mem_hit);
    if (kill || !uses) return 2'b00;
    else if (ex_hit)   return 2'b01;
    else if (mem_hit)  return 2'b10;
    else               return 2'b00;
  endfunction

  always_comb begin
    w_ex_hit_a  = f_match(bus.id_rn, r_ex_valid, r_ex_regwrite, r_ex_rd);
    w_ex_hit_b  = f_match(bus.id_rm, r_ex_valid, r_ex_regwrite, r_ex_rd);
    w_mem_hit_a = f_match(bus.id_rn, r_mem_valid, r_mem_regwrite, r_mem_rd);
    w_mem_hit_b = f_match(bus.id_rm, r_mem_valid, r_mem_regwrite, r_mem_rd);
    w_stall     = bus.id_valid && !bus.flush && r_ex_memread &&
                  ((bus.id_uses_rn && w_ex_hit_a) || (bus.id_uses_rm && w_ex_hit_b));
    w_flag_sel  = bus.id_valid && bus.id_reads_flags && r_ex_valid && r_ex_setflags;
    w_ex_load   = bus.id_valid && !w_stall && !bus.flush;
    w_fwd_a_nxt = f_fwd(!bus.id_valid || w_stall || bus.flush, bus.id_uses_rn,
                        w_ex_hit_a, w_mem_hit_a);
    w_fwd_b_nxt = f_fwd(!bus.id_valid || w_stall || bus.flush, bus.id_uses_rm,
                        w_ex_hit_b, w_mem_hit_b);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= 5'd0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_setflags  <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= 5'd0;
      r_mem_regwrite <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_regwrite  <= 1'b0;
      r_fwd_a        <= 2'b00;
      r_fwd_b        <= 2'b00;
      r_stall_cnt    <= '0;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_ex_load) begin
        r_ex_valid    <= 1'b1;
        r_ex_rd       <= bus.id_rd;
        r_ex_regwrite <= bus.id_regwrite;
        r_ex_memread  <= bus.id_memread;
        r_ex_setflags <= bus.id_setflags;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_rd       <= 5'd0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_ex_setflags <= 1'b0;
      end
      r_fwd_a <= w_fwd_a_nxt;
      r_fwd_b <= w_fwd_b_nxt;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // WB slot only feeds debug visibility; the register file covers that distance
  assign bus.dbg_wb_write = r_wb_valid && r_wb_regwrite;
  assign bus.dbg_wb_rd    = r_wb_rd;
  assign bus.stall        = w_stall;
  assign bus.flag_sel     = w_flag_sel;
  assign bus.fwd_a        = r_fwd_a;
  assign bus.fwd_b        = r_fwd_b;
  assign bus.stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - scoreboard bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    string      nm;
  } fwd_exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   exp_cnt;
  fwd_exp_t sb_q[$];

  ex_hazard_ctrl_if #(.CNT_W(32)) bus();

  ex_hazard_ctrl #(.XZR(31), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered selects appear one edge after the ID cycle that produced them
  always @(posedge clk) begin
    fwd_exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if (bus.fwd_a !== e.fa || bus.fwd_b !== e.fb) begin
        n_fail++;
        $display("FAIL fwd_%s: got a=%b b=%b, expected a=%b b=%b",
                 e.nm, bus.fwd_a, bus.fwd_b, e.fa, e.fb);
      end
    end
  end

  task automatic id_in(input logic v, input logic [4:0] rn, input logic urn,
                       input logic [4:0] rm, input logic urm, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic sf, input logic rf,
                       input logic fl, input logic [1:0] efa, input logic [1:0] efb,
                       input string nm);
    fwd_exp_t e;
    bus.id_valid       = v;
    bus.id_rn          = rn;
    bus.id_uses_rn     = urn;
    bus.id_rm          = rm;
    bus.id_uses_rm     = urm;
    bus.id_rd          = rd;
    bus.id_regwrite    = rw;
    bus.id_memread     = mr;
    bus.id_setflags    = sf;
    bus.id_reads_flags = rf;
    bus.flush          = fl;
    e.fa = efa;
    e.fb = efb;
    e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic fin();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc();
    @(negedge clk);
    fin();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            2'b00, 2'b00, "idle");
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          2'b00, 2'b00, "unused");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_tests += 5;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, expected 0", bus.stall); end
    if (bus.flag_sel !== 1'b0) begin n_fail++; $display("FAIL reset_flag_sel: got %b, expected 0", bus.flag_sel); end
    if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b, expected 00", bus.fwd_a); end
    if (bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b: got %b, expected 00", bus.fwd_b); end
    if (bus.stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d, expected 0", bus.stall_count); end
    @(negedge clk);
    reset = 1'b1;
    fin();
  endtask

  task automatic test_alu_forward();
    drain();
    id_in(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_x1");
    cyc();
    id_in(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, "sub_alu");
    @(negedge clk);
    n_tests++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b, expected 0", bus.stall); end
    fin();
  endtask

  task automatic test_back_to_back();
    drain();
    id_in(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_x1_d2");
    cyc();
    id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "nop");
    cyc();
    id_in(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, "orr_dist2");
    cyc();
    drain();
    id_in(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_x1_a");
    cyc();
    id_in(1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_x1_b");
    cyc();
    id_in(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, "orr_newest");
    cyc();
  endtask

  task automatic test_load_use();
    drain();
    id_in(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "ldur_x7");
    cyc();
    id_in(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_stalled");
    @(negedge clk);
    n_tests += 2;
    if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b, expected 1", bus.stall); end
    if (bus.stall_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL lu_count_before: got %0d, expected %0d", bus.stall_count, exp_cnt); end
    fin();
    exp_cnt++;
    n_tests++;
    if (bus.stall_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL lu_count_after: got %0d, expected %0d", bus.stall_count, exp_cnt); end
    id_in(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, "add_reissue");
    @(negedge clk);
    n_tests++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %b, expected 0", bus.stall); end
    fin();
    n_tests++;
    if (bus.stall_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL lu_count_hold: got %0d, expected %0d", bus.stall_count, exp_cnt); end
    id_in(1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, "use_x8");
    cyc();
  endtask

  task automatic test_xzr();
    drain();
    id_in(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "ldur_x31");
    cyc();
    id_in(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_xzr");
    @(negedge clk);
    n_tests++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL xzr_stall: got %b, expected 0", bus.stall); end
    fin();
    id_in(1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_x1_nr");
    cyc();
    id_in(1'b1, 5'd1, 1'b0, 5'd1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "non_reader");
    cyc();
  endtask

  task automatic test_flags();
    drain();
    id_in(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "subs");
    cyc();
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "bcond_near");
    @(negedge clk);
    n_tests++;
    if (bus.flag_sel !== 1'b1) begin n_fail++; $display("FAIL flag_near: got %b, expected 1", bus.flag_sel); end
    fin();
    id_in(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "subs2");
    cyc();
    id_in(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_gap");
    cyc();
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "bcond_far");
    @(negedge clk);
    n_tests++;
    if (bus.flag_sel !== 1'b0) begin n_fail++; $display("FAIL flag_far: got %b, expected 0", bus.flag_sel); end
    fin();
  endtask

  task automatic test_flush();
    drain();
    id_in(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "ldur_fl");
    cyc();
    id_in(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, "add_flushed");
    @(negedge clk);
    n_tests++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b, expected 0", bus.stall); end
    fin();
    n_tests++;
    if (bus.stall_count !== 32'(exp_cnt)) begin n_fail++; $display("FAIL flush_count: got %0d, expected %0d", bus.stall_count, exp_cnt); end
    id_in(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, "add_after_fl");
    @(negedge clk);
    n_tests++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: got %b, expected 0", bus.stall); end
    fin();
  endtask

  task automatic test_reset_mid_stall();
    drain();
    id_in(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_x3");
    cyc();
    id_in(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, "ldur_fwd");
    cyc();
    id_in(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "add_rst");
    @(negedge clk);
    n_tests++;
    if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %b, expected 1", bus.stall); end
    reset = 1'b0;
    sb_q.delete();
    #1;
    n_tests += 4;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b, expected 0", bus.stall); end
    if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL rst_fwd_a: got %b, expected 00", bus.fwd_a); end
    if (bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL rst_fwd_b: got %b, expected 00", bus.fwd_b); end
    if (bus.stall_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d, expected 0", bus.stall_count); end
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    fin();
    drain();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    test_reset();
    test_alu_forward();
    test_back_to_back();
    test_load_use();
    test_xzr();
    test_flags();
    test_flush();
    test_reset_mid_stall();
    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
